mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, memory byte-address width.
REQ-002 SHALL have parameter DATA_W, default 32, LSB load/store data width.
REQ-003 SHALL have parameter STARVE_MAX, default 4, consecutive ifetch grants allowed while LSB waits.
REQ-004 SHALL have ports: clk in 1 clock; rst in 1 reset; rdy in 1 global enable; rollback in 1 mispredict flush.
REQ-005 One clock, clk; reset rst is synchronous and active-high (polarity and synchronicity fixed).
REQ-006 SHALL have ifetch ports: if_req in 1 request; if_addr in ADDR_W block address; if_done out 1 block-read complete pulse.
REQ-007 SHALL have LSB ports: lsb_req in 1 request; lsb_is_store in 1 store/load; lsb_addr in ADDR_W address; lsb_len in 3 byte count (1/2/4); lsb_wdata in DATA_W store data; lsb_done out 1 completion pulse.
REQ-008 SHALL have memory-controller ports: mc_valid out 1 one-cycle call; mc_is_ifetch out 1; mc_is_store out 1; mc_addr out ADDR_W; mc_len out 3; mc_wdata out DATA_W; mc_done in 1 controller completion pulse.
REQ-009 SHALL have status port busy out 1, high in any state except IDLE.

Function
REQ-010 SHALL implement states IDLE, ISSUE, WAIT.
REQ-011 SHALL hold each request valid until its done pulse; the arbiter samples requests only in IDLE.
REQ-012 SHALL, in IDLE, grant when either request is high and move to ISSUE in the next cycle with the granted request's fields latched.
REQ-013 SHALL, when both requests are high, grant LSB if the last grant was ifetch or starve_cnt equals STARVE_MAX; otherwise grant ifetch (round-robin).
REQ-014 SHALL increment starve_cnt on each ifetch grant made while lsb_req is high, saturating at STARVE_MAX, and clear it on any LSB grant.
REQ-015 SHALL, in ISSUE, assert mc_valid for exactly one cycle with the latched fields, then move to WAIT.
REQ-016 SHALL drive mc_is_ifetch=1, mc_is_store=0 and mc_len=0 for ifetch grants; mc_wdata SHALL equal the latched lsb_wdata for stores and zero otherwise.
REQ-017 SHALL, in WAIT on mc_done, pulse if_done or lsb_done (per grant) for one cycle in the same cycle, then return to IDLE.
REQ-018 SHALL, on rollback while an ifetch or load is in ISSUE or WAIT, return to IDLE next cycle without a done pulse; no mc_valid SHALL be issued from ISSUE that cycle.
REQ-019 SHALL ignore rollback for a granted store; the store runs to mc_done and lsb_done is pulsed.
REQ-020 SHALL grant nothing from IDLE in a cycle where rollback is high.
REQ-021 SHALL freeze all state and outputs except one-cycle pulses (forced low) when rdy is low.
REQ-022 SHALL drop an mc_done arriving outside WAIT.
REQ-023 SHALL take mc_done before rollback when both occur in the same WAIT cycle (done is pulsed).

Reset
REQ-024 SHALL, on rst, enter IDLE, clear starve_cnt, set last grant to LSB (ifetch wins first tie), and drive all outputs to 0.
REQ-025 SHALL override rdy and rollback with rst.

Structure
REQ-026 SHALL place the state encoding, length encoding (LEN_B/H/W) and ADDR_W/DATA_W defaults in the shared constants header.
REQ-027 SHALL implement the arbiter as one module; a sub-module rr_pick (2-way round-robin with starvation counter) is permitted.

Verification
REQ-028 Bench: if_req alone, addr 0x1000 -> mc_valid 1 cycle after grant, mc_is_ifetch=1; mc_done -> if_done same cycle.
REQ-029 Bench: if_req and lsb_req (load, addr 0x20, len 4) together from reset -> ifetch first, then load; mc_len=4.
REQ-030 Bench: if_req held high, lsb_req high, STARVE_MAX=4 -> LSB granted no later than the 2nd grant; starve_cnt never exceeds 4.
REQ-031 Bench: load in WAIT, rollback pulse -> IDLE next cycle, no lsb_done, a later mc_done is ignored.
REQ-032 Bench: store 0xDEADBEEF len 4 in WAIT, rollback -> remains WAIT; mc_done -> lsb_done pulse.
REQ-033 Bench: rdy low for 3 cycles mid-WAIT -> state held, no pulses; rst mid-WAIT -> IDLE, all outputs 0.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_arbiter_pkg
// Shared constants for the memory arbiter.
// The package holds the following items:
//   - The default address and data widths.
//   - The arbiter state encoding.
//   - The access-length encoding that the memory controller understands.
// -----------------------------------------------------------------------------
package mem_arbiter_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } arbState_t;

    // Byte counts for LSB accesses.
    // Instruction fetches always use LEN_NONE, because the controller
    // reads a whole block for them.
    localparam logic [2:0] LEN_NONE = 3'd0;
    localparam logic [2:0] LEN_B    = 3'd1;
    localparam logic [2:0] LEN_H    = 3'd2;
    localparam logic [2:0] LEN_W    = 3'd4;

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Two-way round-robin picker between ifetch and the LSB, with a starvation
// counter.
//
// Ports
//   i_clk, i_rst          : clock and synchronous active-high reset
//   i_take                : the arbiter accepts a grant this cycle
//   i_reqIf / i_reqLsb    : the pending requests
//   o_grantIf/o_grantLsb  : one-hot grant, valid only while i_take is high
// -----------------------------------------------------------------------------
module rr_pick #(
    parameter int STARVE_MAX = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_take,
    input  logic i_reqIf,
    input  logic i_reqLsb,
    output logic o_grantIf,
    output logic o_grantLsb
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    logic             r_lastLsb;
    logic [CNT_W-1:0] r_starveCnt;
    logic             w_lsbWins;

    // The LSB wins a tie when the previous grant went to ifetch,
    // or when it has been starved for the maximum number of cycles.
    always_comb begin
        w_lsbWins = 1'b0;
        if (i_reqLsb && !i_reqIf) begin
            w_lsbWins = 1'b1;
        end else if (i_reqLsb && i_reqIf) begin
            w_lsbWins = !r_lastLsb || (r_starveCnt == CNT_W'(STARVE_MAX));
        end
        o_grantLsb = i_take && w_lsbWins;
        o_grantIf  = i_take && i_reqIf && !w_lsbWins;
    end

    // Last-grant and starvation bookkeeping.
    // After reset, last-grant points at the LSB, so ifetch wins the first tie.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_lastLsb   <= 1'b1;
            r_starveCnt <= '0;
        end else if (o_grantLsb) begin
            r_lastLsb   <= 1'b1;
            r_starveCnt <= '0;
        end else if (o_grantIf) begin
            r_lastLsb <= 1'b0;
            if (i_reqLsb && (r_starveCnt != CNT_W'(STARVE_MAX))) begin
                r_starveCnt <= r_starveCnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Arbitrates between instruction fetch and the load/store buffer for a single
// memory controller.
//
// The arbiter steps through three states:
//   - IDLE : samples the requests and grants one of them.
//   - ISSUE: issues a one-cycle call to the memory controller.
//   - WAIT : waits for the controller's done pulse, then forwards it to
//            the requester that was granted.
//
// A rollback aborts an in-flight ifetch or load. A store that has been
// granted always runs to completion.
//
// Ports
//   i_clk, i_rst, i_rdy, i_rollback : clock, sync reset, global enable, flush
//   i_if_req, i_if_addr, o_if_done  : instruction-fetch requester
//   i_lsb_*, o_lsb_done             : load/store buffer requester
//   o_mc_*, i_mc_done               : memory-controller call and completion
//   o_busy                          : high whenever the arbiter is not IDLE
// -----------------------------------------------------------------------------
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int STARVE_MAX = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_rdy,
    input  logic              i_rollback,
    input  logic              i_if_req,
    input  logic [ADDR_W-1:0] i_if_addr,
    output logic              o_if_done,
    input  logic              i_lsb_req,
    input  logic              i_lsb_is_store,
    input  logic [ADDR_W-1:0] i_lsb_addr,
    input  logic [2:0]        i_lsb_len,
    input  logic [DATA_W-1:0] i_lsb_wdata,
    output logic              o_lsb_done,
    output logic              o_mc_valid,
    output logic              o_mc_is_ifetch,
    output logic              o_mc_is_store,
    output logic [ADDR_W-1:0] o_mc_addr,
    output logic [2:0]        o_mc_len,
    output logic [DATA_W-1:0] o_mc_wdata,
    input  logic              i_mc_done,
    output logic              o_busy
);

    arbState_t         r_state;
    arbState_t         w_nextState;
    logic              r_isIfetch;
    logic              r_isStore;
    logic [ADDR_W-1:0] r_addr;
    logic [2:0]        r_len;
    logic [DATA_W-1:0] r_wdata;

    logic w_take;
    logic w_grantIf;
    logic w_grantLsb;
    logic w_abort;

    // A grant is made only from IDLE, while enabled, and never in a
    // rollback cycle.
    assign w_take  = (r_state == IDLE) && i_rdy && !i_rollback && (i_if_req || i_lsb_req);
    assign w_abort = i_rollback && !r_isStore;

    rr_pick #(
        .STARVE_MAX (STARVE_MAX)
    ) u_pick (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_take     (w_take),
        .i_reqIf    (i_if_req),
        .i_reqLsb   (i_lsb_req),
        .o_grantIf  (w_grantIf),
        .o_grantLsb (w_grantLsb)
    );

    // Next-state logic and the one-cycle pulses.
    // When rdy is low or reset is high, the state holds and all pulses stay low.
    // In WAIT, mc_done is checked before rollback, so a completion that
    // coincides with a flush is still reported.
    always_comb begin
        w_nextState = r_state;
        o_mc_valid  = 1'b0;
        o_if_done   = 1'b0;
        o_lsb_done  = 1'b0;
        if (!i_rst && i_rdy) begin
            case (r_state)
                IDLE: begin
                    if (w_grantIf || w_grantLsb) begin
                        w_nextState = ISSUE;
                    end
                end
                ISSUE: begin
                    if (w_abort) begin
                        w_nextState = IDLE;
                    end else begin
                        o_mc_valid  = 1'b1;
                        w_nextState = WAIT;
                    end
                end
                WAIT: begin
                    if (i_mc_done) begin
                        o_if_done   = r_isIfetch;
                        o_lsb_done  = !r_isIfetch;
                        w_nextState = IDLE;
                    end else if (w_abort) begin
                        w_nextState = IDLE;
                    end
                end
                default: w_nextState = IDLE;
            endcase
        end
    end

    // The controller fields read as zero outside the issue cycle,
    // so a reset leaves every output at 0.
    assign o_mc_is_ifetch = o_mc_valid && r_isIfetch;
    assign o_mc_is_store  = o_mc_valid && r_isStore;
    assign o_mc_addr      = o_mc_valid ? r_addr  : '0;
    assign o_mc_len       = o_mc_valid ? r_len   : LEN_NONE;
    assign o_mc_wdata     = o_mc_valid ? r_wdata : '0;
    assign o_busy         = (r_state != IDLE);

    // State register and latch for the granted request's fields.
    // Store data is kept only for stores, so loads and fetches issue zero
    // write data.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= IDLE;
            r_isIfetch <= 1'b0;
            r_isStore  <= 1'b0;
            r_addr     <= '0;
            r_len      <= LEN_NONE;
            r_wdata    <= '0;
        end else begin
            r_state <= w_nextState;
            if (w_grantIf) begin
                r_isIfetch <= 1'b1;
                r_isStore  <= 1'b0;
                r_addr     <= i_if_addr;
                r_len      <= LEN_NONE;
                r_wdata    <= '0;
            end else if (w_grantLsb) begin
                r_isIfetch <= 1'b0;
                r_isStore  <= i_lsb_is_store;
                r_addr     <= i_lsb_addr;
                r_len      <= i_lsb_len;
                r_wdata    <= i_lsb_is_store ? i_lsb_wdata : '0;
            end
        end
    end

endmodule
